// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder that streams operand nibbles through one 4-bit CLA slice.
// Optional subtract support is enabled by defining CLA_SEQ_SUB_EN.
module cla_seq_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned SH_W    = IDX_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;

  logic [SH_W-1:0]    sh;
  logic [3:0]         a_nib, b_nib, p, g, nib_sum;
  logic [4:0]         c;

  // 4-bit carry-lookahead slice on the current nibble
  always_comb begin
    sh    = {idx_q, 2'b00};
    a_nib = 4'(a_q >> sh);
    b_nib = 4'(b_q >> sh);
    p     = a_nib ^ b_nib;
    g     = a_nib & b_nib;
    c[0]  = carry_q;
    c[1]  = g[0] | (p[0] & c[0]);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c[0]);
    nib_sum = p ^ c[3:0];
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = a;
          idx_d = '0;
          sum_d = '0;
`ifdef CLA_SEQ_SUB_EN
          if (sub) begin
            b_d     = ~b;
            carry_d = 1'b1;
          end else begin
            b_d     = b;
            carry_d = cin;
          end
`else
          b_d     = b;
          carry_d = cin;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = (sum_q & ~(WIDTH'(4'hF) << sh)) | (WIDTH'(nib_sum) << sh);
        carry_d = c[4];
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NIBBLES - 1)) begin
          cout_d  = c[4];
          ovf_d   = c[3] ^ c[4];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
